regfile_mp_sb: RTL
==================

# regfile_mp_sb

Parametrised multi-port register file with integrated scoreboard, for the pipelined datapath. It provides NREAD asynchronous read ports and NWRITE synchronous write ports, with write-through bypass. A per-register pending bit is set when an instruction that targets the register issues, and cleared when that instruction writes back, so decode can detect RAW hazards directly. Register 0 reads as zero, is never written and is never pending.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, ≥2
- NREAD, 2, read ports
- NWRITE, 2, write ports
- AW, $clog2(NREGS), address width; derived, not overridden
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- rd_addr  in  NREAD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data  out  NREAD*XLEN  read data, packed the same way
- rd_busy  out  NREAD  pending status of each read address
- wr_en  in  NWRITE  write enables
- wr_addr  in  NWRITE*AW  write addresses
- wr_data  in  NWRITE*XLEN  write data
- iss_en  in  1  an issuing instruction reserves a destination this cycle
- iss_addr  in  AW  destination being reserved
- err  out  1  sticky flag: writeback to a non-pending register, or duplicate write address in one cycle

## Operation
- Storage regs[1..NREGS-1] of XLEN bits; pend[1..NREGS-1] of 1 bit. Address 0 is hardwired: it reads 0 and is never busy.
- Write: on the clk edge, for each port j with wr_en[j] and wr_addr[j]≠0, set regs[wr_addr[j]] ← wr_data[j].
  - If two ports target the same nonzero address, the highest-index port wins and err is set.
- Read (combinational), for port k:
  - If any enabled write port has the same nonzero address, rd_data = the data of the highest-index matching port (bypass).
  - Otherwise rd_data = regs[rd_addr]. Address 0 always gives 0.
- rd_busy[k] = pend[a] AND NOT (any enabled write to a this cycle) AND NOT (iss_en with iss_addr=a).
  - A write in the same cycle counts as the result being available.
  - An issue in the same cycle does not make its own destination busy to readers in that cycle.
- Scoreboard update on the clk edge:
  - Every enabled writeback to a nonzero address clears pend[addr].
  - Then iss_en with iss_addr≠0 sets pend[iss_addr]. Issue wins over a same-cycle writeback to the same address.
  - iss_addr=0 is ignored.
- err is set on the clk edge when either condition holds:
  - an enabled write to a nonzero address whose pend bit is 0 and that is not being issued in the same cycle;
  - a duplicate write address, as above.
- err stays high until rst. Writes still take effect when err is set.
- Re-issuing to an already pending register is legal: pend stays 1 (a single bit, no count).

## Timing
- Reset value: all regs 0, all pend 0, err 0. Consequently rd_data=0 and rd_busy=0 while rst is asserted.
- rst asserted mid-operation clears state immediately. Writes and issues presented during rst are discarded.
- Write-to-read latency is 0 cycles via bypass. From the next cycle on, data comes from storage.
- Issue-to-busy latency is 1 cycle. Writeback-to-not-busy latency is 0 cycles.
- err rises 1 cycle after the offending write.
- No handshakes and no stalls inside the block. The consumer gates issue on rd_busy.

## Structure
- Shared package regfile_pkg holds the default XLEN/NREGS/NREAD/NWRITE constants and a reg_addr_t typedef sized by the default AW.
- Sub-module regfile_scoreboard holds pend[], the set/clear priority logic and err generation.
- The data array, write-port priority and bypass muxes stay in the top module.

## Test plan
- Reset, then read addresses 0..31 on all ports -> rd_data=0, rd_busy=0, err=0.
- iss 5; next cycle read 5 -> busy=1; then wr port0 5=0xDEADBEEF -> same cycle rd_data=0xDEADBEEF, busy=0; next cycle pend[5]=0.
- wr port0 and port1 both to 7 (0x11, 0x22) with pend[7]=1 -> bypass and stored value are 0x22, err=1 next cycle.
- Same cycle: iss 9 and wr 9=0x5 with pend[9]=1 -> stored 0x5, pend[9]=1 afterwards, err=0.
- wr 0=0xFFFF_FFFF -> read 0 gives 0, no err; wr 12 with pend[12]=0 -> err=1 and stays high until rst.
- Assert rst asynchronously mid-cycle with pend[3]=1 and regs[3]=0xA -> immediately rd_data=0, rd_busy=0, err=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
// No logic here; sizes and the default register-address type only.
// Overriding NREGS on an instance does not resize reg_addr_t.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NREAD_DEF  = 2;
    localparam int NWRITE_DEF = 2;
    localparam int AW_DEF     = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: writeback clears, issue sets (issue wins), sticky err.
// Latency: issue-to-busy 1 cycle, writeback-to-not-busy 0 cycles, err 1 cycle.
// Backpressure: none; the consumer gates issue on rd_busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = NREAD_DEF,
    parameter int NWRITE = NWRITE_DEF,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREAD*AW-1:0]  rd_addr,
    output logic [NREAD-1:0]     rd_busy,
    input  logic [NWRITE-1:0]    wr_en,
    input  logic [NWRITE*AW-1:0] wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic                 err
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [NREGS-1:0] wr_hit;
    logic             err_nxt;

    always_comb begin
        wr_hit  = '0;
        err_nxt = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
                // A same-cycle issue to the target legitimises the writeback.
                if (!pend[wr_addr[j*AW +: AW]] &&
                    !(iss_en && iss_addr == wr_addr[j*AW +: AW]))
                    err_nxt = 1'b1;
                for (int i = 0; i < j; i++) begin
                    if (wr_en[i] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])
                        err_nxt = 1'b1;
                end
            end
        end
        pend_nxt = pend & ~wr_hit;
        if (iss_en && iss_addr != '0)
            pend_nxt[iss_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            err  <= 1'b0;
        end else begin
            pend <= pend_nxt;
            err  <= err | err_nxt;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NREAD; k++) begin
            rd_busy[k] = pend[rd_addr[k*AW +: AW]] &
                         ~wr_hit[rd_addr[k*AW +: AW]] &
                         ~(iss_en && iss_addr == rd_addr[k*AW +: AW]);
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass and integrated scoreboard.
// Latency: reads combinational (0-cycle bypass), writes land on the clk edge.
// Backpressure: none; no handshakes, no stalls.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NREAD  = NREAD_DEF,
    parameter  int NWRITE = NWRITE_DEF,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    output logic                   err
);

    logic [XLEN-1:0] regs [NREGS];

    // Ascending port order: the highest-index port's NBA lands last and wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NREAD; k++) begin
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])
                    rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            end
            // Writes presented during reset are discarded, so no bypass then.
            if (rd_addr[k*AW +: AW] == '0 || rst)
                rd_data[k*XLEN +: XLEN] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .err      (err)
    );

endmodule
